// File: rtl/i2c_byte_writer.sv
// rtl/i2c_byte_writer.sv - write-only I2C master: START, addr+W, ACK, data, ACK, STOP
module i2c_byte_writer #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  input  logic       i2c_sda_in,
  output logic       ready,
  output logic       ack_error,
  output logic       i2c_sda,
  output logic       i2c_scl
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK1,
    ST_DATA,
    ST_ACK2,
    ST_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             ack_error_q, ack_error_d;
  logic             ready_q, ready_d;
  logic             sda_q, sda_d;
  logic             scl_q, scl_d;

  logic             tick;
  logic [2:0]       bit_m1;
  logic             in_ack;

  assign tick   = (state_q != ST_IDLE) && (div_q == DIV_LAST);
  assign bit_m1 = bit_q - 3'd1;
  assign in_ack = (state_q == ST_ACK1) || (state_q == ST_ACK2);

  assign ready     = ready_q;
  assign ack_error = ack_error_q;
  assign i2c_sda   = sda_q;
  assign i2c_scl   = scl_q;

  // Next-state logic: line levels are decided on entry to each quarter so the
  // registered outputs change exactly on the quarter boundary.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    ack_error_d = ack_error_q;
    ready_d     = ready_q;
    sda_d       = sda_q;
    scl_d       = scl_q;

    if (state_q == ST_IDLE || tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d     = {addr, 1'b0};
          data_d      = data;
          ack_error_d = 1'b0;
          state_d     = ST_START;
          qtr_d       = 2'd0;
          ready_d     = 1'b0;
          sda_d       = 1'b1;
          scl_d       = 1'b1;
        end
      end

      ST_START: begin
        if (tick) begin
          if (qtr_q == 2'd0) begin
            qtr_d = 2'd1;
            sda_d = 1'b0;
          end else begin
            state_d = ST_ADDR;
            qtr_d   = 2'd0;
            bit_d   = 3'd7;
            sda_d   = shift_q[7];
            scl_d   = 1'b0;
          end
        end
      end

      ST_ADDR, ST_ACK1, ST_DATA, ST_ACK2: begin
        if (tick) begin
          if (qtr_q != 2'd3) begin
            // Quarters 0,1 hold SCL low; 2,3 hold it high. SDA is left alone.
            qtr_d = qtr_q + 2'd1;
            scl_d = (qtr_q != 2'd0);
            if (in_ack && qtr_q == 2'd2 && i2c_sda_in) begin
              ack_error_d = 1'b1;
            end
          end else begin
            qtr_d = 2'd0;
            scl_d = 1'b0;
            case (state_q)
              ST_ADDR: begin
                if (bit_q != 3'd0) begin
                  bit_d = bit_m1;
                  sda_d = shift_q[bit_m1];
                end else begin
                  state_d = ST_ACK1;
                  sda_d   = 1'b1;
                end
              end
              ST_ACK1: begin
                // ack_error is clear at accept, so a set flag here means this
                // transaction's address was NACKed: skip the data byte.
                if (ack_error_q) begin
                  state_d = ST_STOP;
                  sda_d   = 1'b0;
                end else begin
                  state_d = ST_DATA;
                  bit_d   = 3'd7;
                  sda_d   = data_q[7];
                end
              end
              ST_DATA: begin
                if (bit_q != 3'd0) begin
                  bit_d = bit_m1;
                  sda_d = data_q[bit_m1];
                end else begin
                  state_d = ST_ACK2;
                  sda_d   = 1'b1;
                end
              end
              default: begin
                state_d = ST_STOP;
                sda_d   = 1'b0;
              end
            endcase
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          case (qtr_q)
            2'd0: begin
              qtr_d = 2'd1;
              scl_d = 1'b1;
              sda_d = 1'b0;
            end
            2'd1: begin
              qtr_d = 2'd2;
              scl_d = 1'b1;
              sda_d = 1'b1;
            end
            2'd2: begin
              qtr_d = 2'd3;
            end
            default: begin
              state_d = ST_IDLE;
              qtr_d   = 2'd0;
              ready_d = 1'b1;
            end
          endcase
        end
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        sda_d   = 1'b1;
        scl_d   = 1'b1;
      end
    endcase
  end

  // State register; reset releases both bus lines immediately without a STOP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      qtr_q       <= 2'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      data_q      <= 8'd0;
      ack_error_q <= 1'b0;
      ready_q     <= 1'b1;
      sda_q       <= 1'b1;
      scl_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      ack_error_q <= ack_error_d;
      ready_q     <= ready_d;
      sda_q       <= sda_d;
      scl_q       <= scl_d;
    end
  end

endmodule

// File: tb/tb_i2c_byte_writer.sv
// tb/tb_i2c_byte_writer.sv - directed self-checking bench for i2c_byte_writer
module tb_i2c_byte_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] data = 8'd0;
  logic       i2c_sda_in = 1'b0;
  logic       ready;
  logic       ack_error;
  logic       i2c_sda;
  logic       i2c_scl;

  int n_checks = 0;
  int n_fail = 0;

  i2c_byte_writer #(.CLK_DIV(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .addr       (addr),
    .data       (data),
    .i2c_sda_in (i2c_sda_in),
    .ready      (ready),
    .ack_error  (ack_error),
    .i2c_sda    (i2c_sda),
    .i2c_scl    (i2c_scl)
  );

  always #5 clk = ~clk;

  // Bus monitor: decodes START/STOP conditions, captures SDA on SCL rise,
  // and measures each ready-low window.
  logic [31:0] tx_bits[$];
  int          tx_n[$];
  int          low_len[$];
  int          n_start = 0;
  int          n_stop = 0;
  logic [31:0] cap = 32'd0;
  int          cap_n = 0;
  int          low_cnt = 0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;

  always @(negedge clk) begin
    if (!reset) begin
      cap     = 32'd0;
      cap_n   = 0;
      low_cnt = 0;
    end else begin
      if (prev_scl && i2c_scl && prev_sda && !i2c_sda) begin
        n_start++;
        cap   = 32'd0;
        cap_n = 0;
      end else if (prev_scl && i2c_scl && !prev_sda && i2c_sda) begin
        // Drop the SCL rise of STOP Q1, which is not a data bit.
        n_stop++;
        tx_bits.push_back(cap >> 1);
        tx_n.push_back(cap_n - 1);
      end else if (!prev_scl && i2c_scl) begin
        cap = {cap[30:0], i2c_sda};
        cap_n++;
      end
      if (!ready) begin
        low_cnt++;
      end else if (low_cnt != 0) begin
        low_len.push_back(low_cnt);
        low_cnt = 0;
      end
    end
    prev_scl = i2c_scl;
    prev_sda = i2c_sda;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_full(input logic [6:0] a, input logic [7:0] d);
    return {14'd0, a, 1'b0, 1'b1, d, 1'b1};
  endfunction

  function automatic logic [31:0] exp_nack(input logic [6:0] a);
    return {23'd0, a, 1'b0, 1'b1};
  endfunction

  task automatic clear_mon();
    tx_bits.delete();
    tx_n.delete();
    low_len.delete();
    n_start = 0;
    n_stop  = 0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n = 0;
    while (!ready && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check({tag, "_timeout"}, ready, 1);
    repeat (2) @(negedge clk);
  endtask

  // Presents one request for a single cycle; returns on the first negedge
  // after the accepting posedge.
  task automatic pulse_start(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    addr  = a;
    data  = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic verify_tx(input string tag, input int idx, input logic [31:0] eb,
                           input int en, input int elow);
    if (tx_n.size() > idx) begin
      check($sformatf("%s_bits", tag), tx_bits[idx], eb);
      check($sformatf("%s_nbits", tag), tx_n[idx], en);
    end
    if (low_len.size() > idx) begin
      check($sformatf("%s_ready_low", tag), low_len[idx], elow);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } pkt_t;

  pkt_t pkts[3];

  initial begin
    pkts[0] = '{a: 7'h10, d: 8'h11};
    pkts[1] = '{a: 7'h50, d: 8'hA5};
    pkts[2] = '{a: 7'h7F, d: 8'hFF};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_ack_error", ack_error, 0);
    check("rst_sda", i2c_sda, 1);
    check("rst_scl", i2c_scl, 1);
    reset = 1'b1;

    // Reset in the middle of DATA bit 3 (quarter 55, SCL low, data 0 on SDA)
    clear_mon();
    i2c_sda_in = 1'b0;
    pulse_start(7'h21, 8'h00);
    repeat (110) @(negedge clk);
    check("midrst_pre_scl", i2c_scl, 0);
    check("midrst_pre_sda", i2c_sda, 0);
    check("midrst_pre_ready", ready, 0);
    reset = 1'b0;
    #1;
    check("midrst_sda", i2c_sda, 1);
    check("midrst_scl", i2c_scl, 1);
    check("midrst_ready", ready, 1);
    check("midrst_ack_error", ack_error, 0);
    @(negedge clk);
    reset = 1'b1;
    check("midrst_no_stop", n_stop, 0);

    // Full write after reset release
    clear_mon();
    pulse_start(7'h21, 8'h0A);
    wait_idle("full", 400);
    check("full_ntx", tx_n.size(), 1);
    verify_tx("full", 0, exp_full(7'h21, 8'h0A), 18, 156);
    check("full_ack_error", ack_error, 0);
    check("full_starts", n_start, 1);
    check("full_stops", n_stop, 1);

    // Data NACK: ACK1 driven low, ACK2 high
    clear_mon();
    i2c_sda_in = 1'b0;
    pulse_start(7'h2A, 8'h96);
    repeat (100) @(negedge clk);
    check("dnack_mid_ack_error", ack_error, 0);
    i2c_sda_in = 1'b1;
    wait_idle("dnack", 400);
    check("dnack_ntx", tx_n.size(), 1);
    verify_tx("dnack", 0, exp_full(7'h2A, 8'h96), 18, 156);
    check("dnack_ack_error", ack_error, 1);
    check("dnack_stops", n_stop, 1);

    // Address NACK: flag appears on the ACK1 Q2 tick, no data clocks
    clear_mon();
    i2c_sda_in = 1'b1;
    pulse_start(7'h21, 8'h0A);
    check("anack_cleared", ack_error, 0);
    repeat (73) @(negedge clk);
    check("anack_before_q2", ack_error, 0);
    @(negedge clk);
    check("anack_after_q2", ack_error, 1);
    wait_idle("anack", 400);
    check("anack_ntx", tx_n.size(), 1);
    verify_tx("anack", 0, exp_nack(7'h21), 9, 84);
    check("anack_ack_error", ack_error, 1);
    check("anack_stops", n_stop, 1);

    // Busy ignore and back-to-back with start held high
    clear_mon();
    i2c_sda_in = 1'b0;
    @(negedge clk);
    addr  = 7'h21;
    data  = 8'h5A;
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("b2b_ack_error_cleared", ack_error, 0);
    repeat (40) @(negedge clk);
    addr = 7'h33;
    data = 8'hC3;
    begin
      int n = 0;
      while (!ready && n < 400) begin
        @(negedge clk);
        n++;
      end
    end
    check("b2b_ready_rise", ready, 1);
    @(negedge clk);
    check("b2b_rearm", ready, 0);
    start = 1'b0;
    wait_idle("b2b", 400);
    check("b2b_ntx", tx_n.size(), 2);
    verify_tx("b2b0", 0, exp_full(7'h21, 8'h5A), 18, 156);
    verify_tx("b2b1", 1, exp_full(7'h33, 8'hC3), 18, 156);
    check("b2b_stops", n_stop, 2);

    // Upstream sequencer handshake: wait ready, present, hold until busy
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      wait_idle($sformatf("seq%0d_idle", i), 400);
      addr  = pkts[i].a;
      data  = pkts[i].d;
      start = 1'b1;
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (ready && n < 10);
        if (ready) check($sformatf("seq%0d_accept_timeout", i), ready, 0);
      end
      start = 1'b0;
    end
    wait_idle("seq_end", 400);
    check("seq_ntx", tx_n.size(), 3);
    for (int i = 0; i < 3; i++) begin
      verify_tx($sformatf("seq%0d", i), i, exp_full(pkts[i].a, pkts[i].d), 18, 156);
    end
    check("seq_starts", n_start, 3);
    check("seq_stops", n_stop, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_byte_writer.md
Name: i2c_byte_writer

Overview:
Write-only I2C bus master. It takes one 7-bit slave address and one data byte per transaction and drives the bus sequence START, address+W, ACK, data, ACK, STOP. It sits directly downstream of the packet sequencer, which presents addr/data and pulses start, then waits on ready. It also samples the slave ACK bits and flags NACKs upstream.

Parameters:
CLK_DIV, 125, clk cycles per SCL quarter-period (100 kHz SCL at 50 MHz clk); legal range >= 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  transaction request; sampled only while ready=1
addr  input  7  slave address; latched when start is accepted
data  input  8  payload byte; latched when start is accepted
i2c_sda_in  input  1  bus SDA readback, used for ACK sampling
ready  output  1  high when idle and able to accept start
ack_error  output  1  sticky NACK flag for the last transaction
i2c_sda  output  1  SDA drive; 1 = released/high
i2c_scl  output  1  SCL drive; 1 = released/high

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ready=1, ack_error=0, i2c_sda=1, i2c_scl=1, quarter counter=0. Reset mid-transaction aborts immediately with no STOP; lines go high the same instant.
- Quarter tick: a counter runs 0..CLK_DIV-1 while not IDLE. tick = last count. Each phase below lasts one quarter (CLK_DIV clks).
- Accept: in IDLE with start=1 on a clk edge:
  - latch shift={addr,1'b0} and data;
  - clear ack_error;
  - enter START;
  - ready=0 from the next cycle.
- START (2 quarters):
  - Q0: SCL=1, SDA=1.
  - Q1: SCL=1, SDA=0.
- ADDR (8 bits), ACK1 (1 bit), DATA (8 bits), ACK2 (1 bit). Each bit is 4 quarters:
  - Q0, Q1: SCL=0.
  - Q2, Q3: SCL=1.
  - SDA is updated at entry to Q0 and held for all 4 quarters.
  - Bits are sent MSB first.
  - In ACK slots SDA=1 (released). i2c_sda_in is sampled on the tick edge ending Q2; sampled 1 = NACK.
- NACK handling: on NACK in ACK1 or ACK2, set ack_error=1 and go directly to STOP. On NACK in ACK1 the DATA byte is skipped.
- STOP (4 quarters):
  - Q0: SCL=0, SDA=0.
  - Q1: SCL=1, SDA=0.
  - Q2: SCL=1, SDA=1.
  - Q3: SCL=1, SDA=1 (bus free time).
  - On the tick ending Q3: enter IDLE, ready=1.
- Duration: ready is low for exactly 78*CLK_DIV cycles on a full transaction, or 42*CLK_DIV cycles on an address NACK.
- Bus rule: SDA never changes while SCL=1, except the START Q1 and STOP Q2 transitions.
- start while busy: ignored; addr/data changes while busy have no effect.
- start still high on the cycle ready returns to 1: accepted as a new transaction (back-to-back permitted). The upstream block must deassert start once it has seen ready=0.
- ack_error stays valid and stable from the NACK until the next accept.
- Counters: bit index 3 bits (7..0); quarter-phase 2 bits; divider $clog2(CLK_DIV) bits. No wrap other than the modulo-CLK_DIV divider.

Test Plan:
- Reset mid-byte (CLK_DIV=2): assert reset during DATA bit 3 -> same-cycle i2c_sda=1, i2c_scl=1, ready=1, ack_error=0. After release, a new start is accepted normally.
- Full write (CLK_DIV=2): addr=7'h21, data=8'h0A, start pulsed 1 cycle, i2c_sda_in tied 0 ->
  - SDA bit stream 0x42, ACK, 0x0A, ACK;
  - ready low exactly 156 cycles;
  - ack_error=0;
  - checker confirms no SDA edge while SCL=1 except START/STOP.
- Address NACK (CLK_DIV=2): i2c_sda_in tied 1 -> ack_error=1 after ACK1 Q2, no DATA clocks, STOP follows, ready low exactly 84 cycles.
- Data NACK: i2c_sda_in=0 in ACK1 and 1 in ACK2 -> full data byte sent, ack_error=1, ready low 156 cycles. Next accepted start clears ack_error to 0.
- Busy ignore / back-to-back: start held high continuously with data changed mid-transaction ->
  - first transaction carries the originally latched data;
  - a second transaction starts on the cycle ready rises;
  - the second transaction carries the new data.
- Sequencer handshake: connect the upstream packet sequencer with 3 packets -> three complete transactions, each with STOP, bytes in order, and the sequencer reaches its stop state.
